std_pipe_regs: RTL and testbench
================================

Name: std_pipe_regs

Overview:
- Parametrised multi-stage register pipeline with a valid/ready handshake per stage.
- Successor to the single enable/reset flop. Adds configurable depth, a reset value, bubble collapsing, synchronous flush, a global freeze enable and an occupancy count.
- Used as a generic timing/retiming pipe between datapath blocks.

Parameters:
- WIDTH, 16, data bit width (>=1)
- DEPTH, 2, number of register stages (>=1)
- RST_VAL, 0, value loaded into data registers on reset/flush (WIDTH bits, used only with the optional feature)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous reset, active-high
- en  input  1  global enable; 0 freezes the whole pipe
- flush  input  1  synchronous clear of all stage valids
- in_valid  input  1  upstream data valid
- in_ready  output  1  pipe accepts in_data this cycle
- in_data  input  WIDTH  upstream data
- out_valid  output  1  last stage holds valid data
- out_ready  input  1  downstream accepts out_data
- out_data  output  WIDTH  last stage data
- count  output  $clog2(DEPTH+1)  number of occupied stages

Behaviour:
- Stage i holds v[i] and d[i]; stage 0 is input side, stage DEPTH-1 drives out_*.
- Reset (async, rst=1): all v[i]=0, count=0, out_valid=0, in_ready=0 while rst is high. Data is handled per the optional feature.
- Stage ready: r[DEPTH-1] = !v[DEPTH-1] | out_ready; r[i] = !v[i] | r[i+1].
  - This is a combinational chain, so bubbles collapse.
  - in_ready = en & !flush & r[0].
- Output: out_valid = en & !flush & v[DEPTH-1]; out_data = d[DEPTH-1] (unaffected by en/flush).
- Per cycle with en=1, flush=0, for each stage i:
  - if r[i]: v[i] <= upstream valid, and d[i] <= upstream data when upstream valid. Upstream is in_* for i=0, else stage i-1.
  - if !r[i]: hold.
  - Data registers load only when the upstream valid is 1; a bubble never overwrites d.
- Latency: DEPTH cycles from in_valid&in_ready to out_valid with out_ready held 1. Throughput: 1 word/cycle sustained.
- Full: all v=1 and out_ready=0 -> in_ready=0; contents held.
- Simultaneous full-pipe pop and push: accepted in the same cycle; count unchanged.
- Empty: out_valid=0; in_ready=1 regardless of out_ready.
- en=0: all v and d hold; no handshake completes (in_ready=0, out_valid=0); count holds. en overrides nothing in reset.
- flush=1 (with en=1): all v <= 0 next edge, count <= 0. No input accepted, no output presented that cycle.
- flush with en=0: flush ignored; en gates everything.
- count: registered population of v[]; updates each edge (+1 on push only, -1 on pop only, else unchanged); range 0..DEPTH.
- Reset mid-transfer: contents discarded immediately; pipe is empty after rst deasserts.
- Constraint: out_ready must not depend combinationally on out_valid in the consumer.

Optional Feature:
- Macro: STD_PIPE_DATA_RST_EN.
- Defined:
  - Data registers reset asynchronously to RST_VAL.
  - On flush (en=1), all d[i] <= RST_VAL.
  - out_data = RST_VAL after reset or flush.
- Undefined:
  - Data registers have no reset and ignore flush (area saving).
  - out_data is X after reset until the first word reaches the last stage.
  - Only valid bits and count are reset.

Decomposition:
- Shared package std_pkg: a count-width helper function (clog2 of DEPTH+1) and the default WIDTH/DEPTH localparams shared with other std_ blocks.
- One sub-module, std_pipe_stage: one valid bit plus one data register. Ports: clk, rst, en, flush, up_valid, up_data, dn_ready, v, d, r. The top generates DEPTH instances and the count logic.

Test Plan:
- Reset: rst=1 mid-stream with DEPTH=3 holding 3 words -> out_valid=0 and count=0 asynchronously; after release, in_ready=1. With the macro, out_data=RST_VAL.
- Streaming: DEPTH=3, in_data 0x0001..0x0010 every cycle, out_ready=1 -> first out_valid 3 cycles after the first accept; output order matches input; count steady at 3.
- Backpressure: out_ready=0 and push 0xA1,0xA2,0xA3 into DEPTH=3 -> in_ready=0 on 4th cycle, count=3. Raise out_ready -> 0xA1,0xA2,0xA3 in order, no loss or duplication.
- Bubble collapse: push 0xB1, idle 2 cycles, push 0xB2 with out_ready=0 -> both held in the last two stages, count=2, in_ready=1.
- Flush: pipe holding 2 words, flush=1 for one cycle with in_valid=1 -> in_ready=0 and out_valid=0 that cycle; next cycle count=0, out_valid=0; input word not captured.
- Freeze: en=0 for 5 cycles with in_valid=1, out_ready=1 -> no handshakes, count and out_data unchanged; resumes exactly where it stopped when en=1.

Source files
------------

// File: rtl/std_pkg.sv
// Shared definitions for the std_ block family: default sizes and the
// occupancy-counter width helper.
package std_pkg;

   localparam int STD_WIDTH = 16;
   localparam int STD_DEPTH = 2;

   // Number of bits needed to hold a count in the range 0..depth.
   function automatic int count_w(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/std_pipe_stage.sv
// One pipeline stage: a valid bit plus a data register, with collapsing ready.
// With STD_PIPE_DATA_RST_EN defined, the data register resets and flushes to RST_VAL.
module std_pipe_stage
   import std_pkg::*;
#(
   parameter int               WIDTH   = STD_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   input  logic             dn_ready,
   output logic             v,
   output logic [WIDTH-1:0] d,
   output logic             r
);

   logic             v_q, v_d;
   logic [WIDTH-1:0] d_q, d_d;

   // Ready passes through an empty stage, so bubbles are squeezed out.
   assign r = !v_q | dn_ready;

   always_comb begin
      v_d = v_q;
      d_d = d_q;
      if (en & flush) begin
         v_d = 1'b0;
`ifdef STD_PIPE_DATA_RST_EN
         d_d = RST_VAL;
`endif
      end else if (en & r) begin
         v_d = up_valid;
         if (up_valid) d_d = up_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v_q <= 1'b0;
      else     v_q <= v_d;
   end

`ifdef STD_PIPE_DATA_RST_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) d_q <= RST_VAL;
      else     d_q <= d_d;
   end
`else
   always_ff @(posedge clk) begin
      d_q <= d_d;
   end
`endif

   assign v = v_q;
   assign d = d_q;

endmodule

// File: rtl/std_pipe_regs.sv
// Multi-stage valid/ready register pipe with flush, global freeze and occupancy count.
// Optional data reset/flush to RST_VAL is enabled by defining STD_PIPE_DATA_RST_EN.
module std_pipe_regs
   import std_pkg::*;
#(
   parameter int               WIDTH   = STD_WIDTH,
   parameter int               DEPTH   = STD_DEPTH,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [WIDTH-1:0]          in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [WIDTH-1:0]          out_data,
   output logic [count_w(DEPTH)-1:0] count
);

   localparam int CW = count_w(DEPTH);

   logic          push, pop;
   logic [CW-1:0] count_q, count_d;

   // Handshake: a word moves on a port in a cycle where valid and ready are
   // both high at the rising edge; valid never waits on ready, and both are
   // forced low while en is 0, flush is 1 or rst is 1.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic             up_v, dn_r, v_o, r_o;
      logic [WIDTH-1:0] up_d, d_o;

      if (i == 0) begin : g_head
         assign up_v = in_valid;
         assign up_d = in_data;
      end else begin : g_body
         assign up_v = g_stage[i-1].v_o;
         assign up_d = g_stage[i-1].d_o;
      end

      if (i == DEPTH - 1) begin : g_tail
         assign dn_r = out_ready;
      end else begin : g_link
         assign dn_r = g_stage[i+1].r_o;
      end

      std_pipe_stage #(
         .WIDTH   (WIDTH),
         .RST_VAL (RST_VAL)
      ) u_stage (
         .clk      (clk),
         .rst      (rst),
         .en       (en),
         .flush    (flush),
         .up_valid (up_v),
         .up_data  (up_d),
         .dn_ready (dn_r),
         .v        (v_o),
         .d        (d_o),
         .r        (r_o)
      );
   end

   assign in_ready  = en & !flush & !rst & g_stage[0].r_o;
   assign out_valid = en & !flush & g_stage[DEPTH-1].v_o;
   assign out_data  = g_stage[DEPTH-1].d_o;

   assign push = in_valid & in_ready;
   assign pop  = out_valid & out_ready;

   always_comb begin
      count_d = count_q;
      if (en & flush)        count_d = '0;
      else if (push & !pop)  count_d = count_q + CW'(1);
      else if (pop & !push)  count_d = count_q - CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) count_q <= '0;
      else     count_q <= count_d;
   end

   assign count = count_q;

endmodule

// File: tb/tb_std_pipe_regs.sv
// Self-checking bench for std_pipe_regs (DEPTH=3): directed test-plan steps
// followed by random traffic, compared against a queue-of-words reference model.
module tb_std_pipe_regs;

   localparam int               W       = 16;
   localparam int               D       = 3;
   localparam logic [W-1:0]     RST_VAL = 16'h5A5A;

   logic         clk = 1'b0;
   logic         rst, en, flush, in_valid, out_ready;
   logic         in_ready, out_valid;
   logic [W-1:0] in_data, out_data;
   logic [1:0]   count;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: words in arrival order (index 0 = oldest) with the
   // stage position each currently sits in.
   logic [W-1:0] exp_q[$];
   int           pos_q[$];
   logic         mv [D];
   logic         exp_ir, exp_ov;
   logic [W-1:0] last_data;
   logic         last_known;

   std_pipe_regs #(.WIDTH(W), .DEPTH(D), .RST_VAL(RST_VAL)) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      compared++;
      assert (got === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // A word advances if the slot ahead is free or its occupant advances;
   // the oldest word leaves from the last slot only when out_ready is high.
   task automatic model_eval();
      int n;
      n = pos_q.size();
      for (int k = 0; k < n; k++) begin
         if (k == 0) mv[k] = (pos_q[0] == D - 1) ? out_ready : 1'b1;
         else        mv[k] = (pos_q[k] + 1 == pos_q[k-1]) ? mv[k-1] : 1'b1;
      end
      exp_ov = en && !flush && n > 0 && pos_q[0] == D - 1;
      exp_ir = en && !flush && !rst &&
               (n == 0 || pos_q[n-1] != 0 || mv[n-1]);
   endtask

   task automatic model_clear();
      exp_q.delete();
      pos_q.delete();
   endtask

   task automatic model_update();
      logic [W-1:0] nd[$];
      int           np[$];
      if (en && flush) begin
         model_clear();
`ifdef STD_PIPE_DATA_RST_EN
         last_data  = RST_VAL;
         last_known = 1'b1;
`endif
      end else if (en) begin
         for (int k = 0; k < pos_q.size(); k++) begin
            if (!mv[k]) begin
               nd.push_back(exp_q[k]);
               np.push_back(pos_q[k]);
            end else if (pos_q[k] != D - 1) begin
               nd.push_back(exp_q[k]);
               np.push_back(pos_q[k] + 1);
               if (pos_q[k] + 1 == D - 1) begin
                  last_data  = exp_q[k];
                  last_known = 1'b1;
               end
            end
         end
         if (in_valid && exp_ir) begin
            nd.push_back(in_data);
            np.push_back(0);
         end
         exp_q = nd;
         pos_q = np;
      end
   endtask

   // One clock: check outputs at the falling edge, advance model at the rising edge.
   task automatic step();
      model_eval();
      @(negedge clk);
      chk("in_ready", in_ready, exp_ir);
      chk("out_valid", out_valid, exp_ov);
      chk("count", count, pos_q.size());
      if (last_known) chk("out_data", out_data, last_data);
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic drive(input logic v, input logic [W-1:0] dat, input logic ordy);
      in_valid  = v;
      in_data   = dat;
      out_ready = ordy;
      step();
   endtask

   task automatic async_reset();
      rst = 1'b1;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_count", count, 0);
      chk("rst_in_ready", in_ready, 1'b0);
`ifdef STD_PIPE_DATA_RST_EN
      chk("rst_out_data", out_data, RST_VAL);
      last_data  = RST_VAL;
      last_known = 1'b1;
`else
      last_known = 1'b0;
`endif
      model_clear();
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b1; flush = 1'b0;
      in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
      last_known = 1'b0;
      #1;
      async_reset();

      // Streaming with out_ready held high
      for (int i = 1; i <= 16; i++) drive(1'b1, W'(i), 1'b1);
      for (int i = 0; i < 4; i++)   drive(1'b0, '0, 1'b1);

      // Backpressure: fill, attempt a fourth push, then drain
      drive(1'b1, 16'h00A1, 1'b0);
      drive(1'b1, 16'h00A2, 1'b0);
      drive(1'b1, 16'h00A3, 1'b0);
      drive(1'b1, 16'h00A4, 1'b0);
      chk("bp_count_full", count, 3);
      for (int i = 0; i < 4; i++) drive(1'b0, '0, 1'b1);

      // Bubble collapse
      drive(1'b1, 16'h00B1, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b0, '0, 1'b0);
      drive(1'b1, 16'h00B2, 1'b0);
      drive(1'b0, '0, 1'b0);
      chk("bubble_count", count, 2);
      chk("bubble_in_ready", in_ready, 1'b1);

      // Flush with a word offered in the same cycle
      flush = 1'b1;
      drive(1'b1, 16'h00C1, 1'b1);
      flush = 1'b0;
      drive(1'b0, '0, 1'b0);
      chk("flush_count", count, 0);

      // Freeze with traffic pending on both sides
      drive(1'b1, 16'h00D1, 1'b0);
      drive(1'b1, 16'h00D2, 1'b0);
      drive(1'b1, 16'h00D3, 1'b0);
      en = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b1, 16'h00E0 + W'(i), 1'b1);
      en = 1'b1;
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);

      // Reset with a full pipe
      drive(1'b1, 16'h00F1, 1'b0);
      drive(1'b1, 16'h00F2, 1'b0);
      drive(1'b1, 16'h00F3, 1'b0);
      async_reset();
      drive(1'b0, '0, 1'b1);

      // Random traffic
      for (int i = 0; i < 400; i++) begin
         en    = ($urandom_range(0, 9) != 0);
         flush = ($urandom_range(0, 19) == 0);
         drive(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)));
      end
      en = 1'b1; flush = 1'b0;
      for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
